// File: rtl/move_entry_if.sv
// Move-offer and verdict channel between the move-entry controller and game logic.
interface move_entry_if;
   logic       move_valid;
   logic [5:0] move_src;
   logic [5:0] move_dst;
   logic       move_ready;
   logic       rsp_valid;
   logic       rsp_legal;

   // Controller side: offers the move and receives the verdict.
   modport master (
      output move_valid, move_src, move_dst,
      input  move_ready, rsp_valid, rsp_legal
   );

   // Game-logic side: accepts the move and returns the verdict.
   modport slave (
      input  move_valid, move_src, move_dst,
      output move_ready, rsp_valid, rsp_legal
   );
endinterface

// File: rtl/move_entry.sv
// Player move-entry controller: moves an 8x8 cursor from button pulses,
// captures source and destination squares, offers the move to game logic
// and tracks the side to move from the returned verdict.
//
// Handshake: move_valid rises with a stable {move_src, move_dst} payload and
// stays high, payload frozen, until a rising edge sees move_ready=1; it
// drops on the following cycle. A verdict (rsp_valid/rsp_legal) is only
// honoured once the transfer has completed, i.e. in WAIT_RSP.
module move_entry #(
   parameter int WRAP     = 1,
   parameter int INIT_ROW = 7,
   parameter int INIT_COL = 4
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       BtnU_pulse,
   input  logic       BtnD_pulse,
   input  logic       BtnL_pulse,
   input  logic       BtnR_pulse,
   input  logic       BtnC_pulse,
   output logic [2:0] cur_row,
   output logic [2:0] cur_col,
   output logic       src_sel,
   output logic [2:0] src_row,
   output logic [2:0] src_col,
   output logic       side_to_move,
   output logic       err_pulse,
   output logic [1:0] dbg_state,
   move_entry_if.master bus
);

   typedef enum logic [1:0] {
      SEL_SRC  = 2'd0,
      SEL_DST  = 2'd1,
      REQ      = 2'd2,
      WAIT_RSP = 2'd3
   } state_t;

   localparam logic [2:0] P_INIT_ROW = 3'(INIT_ROW);
   localparam logic [2:0] P_INIT_COL = 3'(INIT_COL);
   localparam bit         P_WRAP     = (WRAP != 0);

   state_t     r_state, w_nxt_state;
   logic [2:0] r_cur_row, r_cur_col, w_nxt_row, w_nxt_col;
   logic       r_src_sel, w_nxt_src_sel;
   logic [2:0] r_src_row, r_src_col, w_nxt_src_row, w_nxt_src_col;
   logic       r_move_valid, w_nxt_move_valid;
   logic [5:0] r_move_src, r_move_dst, w_nxt_move_src, w_nxt_move_dst;
   logic       r_side, w_nxt_side;
   logic       r_err, w_nxt_err;
   logic       w_move_en;
   logic       w_same_sq;

   assign w_move_en = (r_state == SEL_SRC) || (r_state == SEL_DST);
   // Compare against the pre-movement cursor so a same-cycle step does not affect C.
   assign w_same_sq = (r_cur_row == r_src_row) && (r_cur_col == r_src_col);

   // Next cursor position: opposing pulses cancel, edges wrap or saturate.
   always_comb begin
      w_nxt_row = r_cur_row;
      w_nxt_col = r_cur_col;
      if (w_move_en) begin
         if (BtnU_pulse && !BtnD_pulse) begin
            if (P_WRAP || (r_cur_row != 3'd0)) w_nxt_row = r_cur_row - 3'd1;
         end else if (BtnD_pulse && !BtnU_pulse) begin
            if (P_WRAP || (r_cur_row != 3'd7)) w_nxt_row = r_cur_row + 3'd1;
         end
         if (BtnL_pulse && !BtnR_pulse) begin
            if (P_WRAP || (r_cur_col != 3'd0)) w_nxt_col = r_cur_col - 3'd1;
         end else if (BtnR_pulse && !BtnL_pulse) begin
            if (P_WRAP || (r_cur_col != 3'd7)) w_nxt_col = r_cur_col + 3'd1;
         end
      end
   end

   // Next state and next values of the registered move/verdict outputs.
   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_src_sel    = r_src_sel;
      w_nxt_src_row    = r_src_row;
      w_nxt_src_col    = r_src_col;
      w_nxt_move_valid = r_move_valid;
      w_nxt_move_src   = r_move_src;
      w_nxt_move_dst   = r_move_dst;
      w_nxt_side       = r_side;
      w_nxt_err        = 1'b0;
      case (r_state)
         SEL_SRC: begin
            if (BtnC_pulse) begin
               w_nxt_src_sel = 1'b1;
               w_nxt_src_row = r_cur_row;
               w_nxt_src_col = r_cur_col;
               w_nxt_state   = SEL_DST;
            end
         end
         SEL_DST: begin
            if (BtnC_pulse) begin
               if (w_same_sq) begin
                  // Re-selecting the source square cancels the selection.
                  w_nxt_src_sel = 1'b0;
                  w_nxt_state   = SEL_SRC;
               end else begin
                  w_nxt_move_src   = {r_src_row, r_src_col};
                  w_nxt_move_dst   = {r_cur_row, r_cur_col};
                  w_nxt_move_valid = 1'b1;
                  w_nxt_state      = REQ;
               end
            end
         end
         REQ: begin
            if (bus.move_ready) begin
               w_nxt_move_valid = 1'b0;
               w_nxt_state      = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (bus.rsp_valid) begin
               if (bus.rsp_legal) w_nxt_side = ~r_side;
               else               w_nxt_err  = 1'b1;
               w_nxt_src_sel = 1'b0;
               w_nxt_state   = SEL_SRC;
            end
         end
         default: w_nxt_state = SEL_SRC;
      endcase
   end

   // State register; reset abandons any move in flight.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= SEL_SRC;
      else          r_state <= w_nxt_state;
   end

   // Registered cursor, selection, move payload and verdict outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cur_row    <= P_INIT_ROW;
         r_cur_col    <= P_INIT_COL;
         r_src_sel    <= 1'b0;
         r_src_row    <= 3'd0;
         r_src_col    <= 3'd0;
         r_move_valid <= 1'b0;
         r_move_src   <= 6'd0;
         r_move_dst   <= 6'd0;
         r_side       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_cur_row    <= w_nxt_row;
         r_cur_col    <= w_nxt_col;
         r_src_sel    <= w_nxt_src_sel;
         r_src_row    <= w_nxt_src_row;
         r_src_col    <= w_nxt_src_col;
         r_move_valid <= w_nxt_move_valid;
         r_move_src   <= w_nxt_move_src;
         r_move_dst   <= w_nxt_move_dst;
         r_side       <= w_nxt_side;
         r_err        <= w_nxt_err;
      end
   end

   assign cur_row        = r_cur_row;
   assign cur_col        = r_cur_col;
   assign src_sel        = r_src_sel;
   assign src_row        = r_src_row;
   assign src_col        = r_src_col;
   assign side_to_move   = r_side;
   assign err_pulse      = r_err;
   assign dbg_state      = r_state;
   assign bus.move_valid = r_move_valid;
   assign bus.move_src   = r_move_src;
   assign bus.move_dst   = r_move_dst;

endmodule

// File: doc/move_entry.md
# move_entry

Player move-entry controller: the consumer end of the debounced button-pulse interface. It takes the single-cycle BtnU/D/L/R/C pulses and moves an 8×8 board cursor. It captures a source square and then a destination square, and offers the resulting move to game logic over a valid/ready handshake. It then waits for a legal/illegal verdict and tracks whose turn it is. It sits between the five debouncers and the game-logic block, in the debounce clock domain.

## Interface
- WRAP, 1, 1: cursor wraps at board edges (7→0, 0→7); 0: cursor saturates at edges
- INIT_ROW, 7, cursor row after reset (0..7)
- INIT_COL, 4, cursor column after reset (0..7)

- CLK  in  1  single clock (debounce/game-logic clock); all logic on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse, BtnC_pulse  in  1 each  one-cycle pulses from the debouncers
- cur_row, cur_col  out  3 each  cursor position; row 0 is the top of the board
- src_sel  out  1  a source square is latched (used for display highlight)
- src_row, src_col  out  3 each  latched source square, valid while src_sel=1
- move_valid  out  1  move offer to game logic
- move_src, move_dst  out  6 each  {row,col} of source and destination
- move_ready  in  1  game logic accepts the move
- rsp_valid  in  1  one-cycle verdict strobe from game logic
- rsp_legal  in  1  verdict, qualified by rsp_valid
- side_to_move  out  1  0 = white, 1 = black
- err_pulse  out  1  one-cycle pulse on an illegal move

## Operation
- States: SEL_SRC, SEL_DST, REQ, WAIT_RSP. Reset state is SEL_SRC.
- Cursor movement is active only in SEL_SRC and SEL_DST. Directional pulses are ignored in REQ and WAIT_RSP.
- U decrements the row, D increments it, L decrements the column, R increments it.
  - U and D in the same cycle: no row change.
  - L and R in the same cycle: no column change.
  - Row and column may change in the same cycle.
- Edges: with WRAP=1, 3-bit modulo arithmetic. With WRAP=0, U at row 0, D at row 7, L at col 0 and R at col 7 leave the cursor unchanged.
- BtnC uses the cursor value from before any same-cycle movement. The movement itself still applies.
- SEL_SRC + C: latch the cursor as the source, set src_sel=1, go to SEL_DST.
- SEL_DST + C with cursor equal to the source: cancel. Clear src_sel and return to SEL_SRC. No request is issued.
- SEL_DST + C with a different square: set move_src = source and move_dst = cursor, assert move_valid, go to REQ.
- REQ: hold move_valid=1 with move_src and move_dst stable. A rising edge with move_ready=1 completes the transfer: move_valid drops on the next cycle and the state goes to WAIT_RSP. C pulses are ignored.
- WAIT_RSP: C pulses are ignored. On rsp_valid:
  - rsp_legal=1: toggle side_to_move, clear src_sel, go to SEL_SRC.
  - rsp_legal=0: err_pulse=1 for one cycle, clear src_sel, go to SEL_SRC. side_to_move is unchanged.
- rsp_valid is ignored in every state except WAIT_RSP, including the acceptance cycle of REQ.
- The cursor is not moved by a move completion. It stays where the player left it.

## Timing
- Reset values:
  - state SEL_SRC
  - cur_row=INIT_ROW, cur_col=INIT_COL
  - src_sel=0, src_row=0, src_col=0
  - move_valid=0, move_src=0, move_dst=0
  - side_to_move=0, err_pulse=0
- All outputs are registered. Latency from input to output is one cycle:
  - a pulse at edge N shows the new cursor after edge N
  - a destination C at edge N gives move_valid=1 after edge N
- Handshake: move_valid never deasserts before acceptance, and the payload does not change while move_valid=1. move_ready may be held high permanently; acceptance then takes exactly one cycle in REQ.
- The earliest rsp_valid that is honoured is one cycle after acceptance. There is no timeout in WAIT_RSP; the block waits indefinitely.
- RESET_N assertion in any state, including mid-handshake, immediately forces all reset values. A pending move is dropped, with no acceptance required.

## Test plan
- Reset, then R,R,D pulses → cur=(row 7,col 6) with WRAP=1 D wraps: after R,R cursor (7,6); D → (0,6). Check WRAP=0 variant: D at row 7 → stays (7,6).
- U+D and L+R in the same cycle from (3,3) → cursor stays (3,3). U+L → (2,2).
- C at (6,4), U, U, C at (4,4), move_ready held low for 5 cycles → move_valid=1 with move_src=0x34 and move_dst=0x24 stable all 5 cycles. Raise move_ready → move_valid=0 next cycle.
- After acceptance: rsp_valid=1, rsp_legal=1 → side_to_move=1 and src_sel=0. Repeat with rsp_legal=0 → err_pulse high for exactly 1 cycle and side_to_move unchanged.
- C at (2,5), then C at (2,5) → src_sel=0 and move_valid never asserted. Directional and C pulses during REQ and WAIT_RSP leave the cursor and state unchanged.
- Drop RESET_N while in REQ with move_valid=1 → move_valid=0, cursor=(7,4) and state SEL_SRC immediately. rsp_valid after release has no effect.
